// File: rtl/video_pattern_gen.sv
// Free-running video timing and test-pattern source, one pixel per clock.
// Define VIDEO_PATTERN_GEN_SCROLL_EN to scroll the pattern left one pixel per frame.
module video_pattern_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic [1:0] pattern_sel_i,
    output logic [7:0] red_o,
    output logic [7:0] green_o,
    output logic [7:0] blue_o,
    output logic       dv_o,
    output logic       hs_o,
    output logic       vs_o,
    output logic       sof_o
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int BAR_W = H_ACTIVE / 8;

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic [1:0]    sel_q;
    logic [1:0]    sel_cur;
    logic          h_wrap;
    logic          v_wrap;
    logic          frame_start;
    logic          act;
    logic          hs_n;
    logic          vs_n;
    logic [15:0]   x;
    logic [7:0]    x8;
    logic [7:0]    v8;
    logic [2:0]    bar;
    logic [7:0]    r_n;
    logic [7:0]    g_n;
    logic [7:0]    b_n;

`ifdef VIDEO_PATTERN_GEN_SCROLL_EN
    logic [7:0]    f;
`endif

    always_comb begin
        h_wrap      = (h == HW'(H_TOT - 1));
        v_wrap      = (v == VW'(V_TOT - 1));
        frame_start = (h == '0) && (v == '0);
        // the frame's pattern is the one presented on its first pixel
        sel_cur     = frame_start ? pattern_sel_i : sel_q;
`ifdef VIDEO_PATTERN_GEN_SCROLL_EN
        x = 16'((32'(h) + 32'(f)) % H_ACTIVE);
`else
        x = 16'(h);
`endif
        x8   = 8'(x);
        v8   = 8'(v);
        act  = (32'(h) < H_ACTIVE) && (32'(v) < V_ACTIVE);
        hs_n = (32'(h) >= H_ACTIVE + H_FP)
            && (32'(h) < H_ACTIVE + H_FP + H_SYNC);
        vs_n = (32'(v) >= V_ACTIVE + V_FP)
            && (32'(v) < V_ACTIVE + V_FP + V_SYNC);
        bar  = 3'(32'(x) / BAR_W);
        r_n  = '0;
        g_n  = '0;
        b_n  = '0;
        if (act) begin
            unique case (sel_cur)
                2'd0: begin
                    r_n = {8{~bar[1]}};
                    g_n = {8{~bar[2]}};
                    b_n = {8{~bar[0]}};
                end
                2'd1: begin
                    r_n = x8;
                    g_n = x8;
                    b_n = x8;
                end
                2'd2: begin
                    r_n = {8{x8[3] ^ v8[3]}};
                    g_n = {8{x8[3] ^ v8[3]}};
                    b_n = {8{x8[3] ^ v8[3]}};
                end
                default: begin
                    r_n = v8;
                    g_n = v8;
                    b_n = v8;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !en_i) begin
            h       <= '0;
            v       <= '0;
            red_o   <= '0;
            green_o <= '0;
            blue_o  <= '0;
            dv_o    <= 1'b0;
            sof_o   <= 1'b0;
            hs_o    <= ~HS_POL;
            vs_o    <= ~VS_POL;
`ifdef VIDEO_PATTERN_GEN_SCROLL_EN
            f       <= '0;
`endif
            if (rst) sel_q <= '0;
        end else begin
            sel_q   <= sel_cur;
            red_o   <= r_n;
            green_o <= g_n;
            blue_o  <= b_n;
            dv_o    <= act;
            sof_o   <= act && frame_start;
            hs_o    <= hs_n ? HS_POL : ~HS_POL;
            vs_o    <= vs_n ? VS_POL : ~VS_POL;
            if (h_wrap) begin
                h <= '0;
                v <= v_wrap ? '0 : v + 1'b1;
`ifdef VIDEO_PATTERN_GEN_SCROLL_EN
                if (v_wrap) f <= f + 8'd1;
`endif
            end else begin
                h <= h + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Randomised and directed bench for video_pattern_gen
// against a frame-arithmetic reference model.
module tb_video_pattern_gen;

    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 4,  VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en_i = 1'b0;
    logic [1:0] pattern_sel_i = 2'd0;
    logic [7:0] red_o, green_o, blue_o;
    logic       dv_o, hs_o, vs_o, sof_o;

    always #5 clk = ~clk;

    video_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .en_i(en_i),
        .pattern_sel_i(pattern_sel_i),
        .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
        .dv_o(dv_o), .hs_o(hs_o), .vs_o(vs_o), .sof_o(sof_o)
    );

    int checks = 0;
    int errors = 0;

    bit          m_act = 1'b0;
    int          m_idx = 0;
    int          m_sel = 0;
    logic [27:0] exp_v = '0;
    logic [27:0] dut_v;
    logic [23:0] bar_rgb [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF,
        24'h00FF00, 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    assign dut_v = {red_o, green_o, blue_o, dv_o, hs_o, vs_o, sof_o};

    function automatic logic [27:0] model_pix(int idx, int sel);
        int h, v, x;
        logic [23:0] c;
        logic dv, hs, vs, sof;
        h = idx % HT;
        v = (idx / HT) % VT;
`ifdef VIDEO_PATTERN_GEN_SCROLL_EN
        x = (h + (idx / FT) % 256) % HA;
`else
        x = h;
`endif
        dv  = (h < HA) && (v < VA);
        hs  = (h >= HA + HF) && (h < HA + HF + HS);
        vs  = (v >= VA + VF) && (v < VA + VF + VS);
        sof = dv && (h == 0) && (v == 0);
        c = 24'h0;
        if (dv) begin
            case (sel)
                0: c = bar_rgb[x / (HA / 8)];
                1: c = {3{8'(x % 256)}};
                2: c = (((x / 8) + (v / 8)) % 2 == 1) ? 24'hFFFFFF : 24'h0;
                default: c = {3{8'(v % 256)}};
            endcase
        end
        return {c, dv, hs, vs, sof};
    endfunction

    task automatic step(input bit r, input bit e, input logic [1:0] s);
        rst = r;
        en_i = e;
        pattern_sel_i = s;
        @(posedge clk);
        if (r || !e) begin
            m_act = 1'b0;
        end else begin
            if (!m_act) begin
                m_act = 1'b1;
                m_idx = 0;
            end else begin
                m_idx++;
            end
            if (m_idx % FT == 0) m_sel = int'(s);
        end
        #1;
        exp_v = m_act ? model_pix(m_idx, m_sel) : 28'h0;
    endtask

    task automatic restart();
        step(1'b1, 1'b0, 2'd0);
        step(1'b1, 1'b0, 2'd0);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b1, 2'd3);
            checks++;
            if (dut_v !== 28'h0) begin
                errors++;
                $display("FAIL reset_idle k=%0d got=%h exp=%h", k, dut_v, 28'h0);
            end
        end
    endtask

    task automatic test_first_frame();
        int dvcnt, sofcnt, hs_first, hs_last, vs_first, vs_last;
        logic [23:0] rgb;
        dvcnt = 0; sofcnt = 0;
        hs_first = -1; hs_last = -1; vs_first = -1; vs_last = -1;
        restart();
        for (int c = 1; c <= 200; c++) begin
            step(1'b0, 1'b1, 2'd0);
            checks++;
            if (dut_v !== exp_v) begin
                errors++;
                $display("FAIL frame0_pix c=%0d got=%h exp=%h", c, dut_v, exp_v);
            end
            if (c <= FT && dv_o === 1'b1) dvcnt++;
            if (sof_o === 1'b1) sofcnt++;
            if (c <= HT && hs_o === 1'b1) begin
                if (hs_first < 0) hs_first = c;
                hs_last = c;
            end
            if (c <= FT && vs_o === 1'b1) begin
                if (vs_first < 0) vs_first = c;
                vs_last = c;
            end
            rgb = {red_o, green_o, blue_o};
            if (c == 1 || c == 3 || c == 16) begin
                checks++;
                if (rgb !== (c == 1 ? 24'hFFFFFF : c == 3 ? 24'hFFFF00 : 24'h0)) begin
                    errors++;
                    $display("FAIL bar_pixel c=%0d got=%h", c, rgb);
                end
            end
            if (c == 1 || c == 193) begin
                checks++;
                if (sof_o !== 1'b1 || dv_o !== 1'b1) begin
                    errors++;
                    $display("FAIL sof_pos c=%0d got sof=%b dv=%b exp=1,1", c, sof_o, dv_o);
                end
            end
        end
        checks++;
        if (dvcnt != 64) begin
            errors++;
            $display("FAIL dv_count got=%0d exp=64", dvcnt);
        end
        checks++;
        if (sofcnt != 2) begin
            errors++;
            $display("FAIL sof_count got=%0d exp=2", sofcnt);
        end
        checks++;
        if (hs_first != 19 || hs_last != 21) begin
            errors++;
            $display("FAIL hs_window got=%0d..%0d exp=19..21", hs_first, hs_last);
        end
        checks++;
        if (vs_first != 121 || vs_last != 168) begin
            errors++;
            $display("FAIL vs_window got=%0d..%0d exp=121..168", vs_first, vs_last);
        end
    endtask

    task automatic test_checker();
        restart();
        for (int c = 1; c <= FT; c++) begin
            step(1'b0, 1'b1, 2'd2);
            checks++;
            if (dut_v !== exp_v) begin
                errors++;
                $display("FAIL checker_pix c=%0d got=%h exp=%h", c, dut_v, exp_v);
            end
            if (dv_o === 1'b0) begin
                checks++;
                if ({red_o, green_o, blue_o} !== 24'h0) begin
                    errors++;
                    $display("FAIL blank_rgb c=%0d got=%h exp=0", c, {red_o, green_o, blue_o});
                end
            end
            if (c == 1 || c == 9 || c == 73 || c == 81) begin
                checks++;
                if (red_o !== ((c == 9 || c == 81) ? 8'hFF : 8'h00)) begin
                    errors++;
                    $display("FAIL checker_fixed c=%0d got=%h", c, red_o);
                end
            end
        end
    endtask

    task automatic test_sel_change();
        restart();
        for (int k = 0; k < 215; k++) begin
            step(1'b0, 1'b1, (k >= 50) ? 2'd1 : 2'd0);
            checks++;
            if (dut_v !== exp_v) begin
                errors++;
                $display("FAIL selchg_pix c=%0d got=%h exp=%h", k + 1, dut_v, exp_v);
            end
            if (k + 1 == 60) begin
                checks++;
                if ({red_o, green_o, blue_o} !== 24'hFF0000) begin
                    errors++;
                    $display("FAIL no_tear got=%h exp=ff0000", {red_o, green_o, blue_o});
                end
            end
            if (k + 1 >= 193 && k + 1 <= 208) begin
                checks++;
                if (green_o !== 8'(k - 192)) begin
                    errors++;
                    $display("FAIL ramp_next c=%0d got=%h exp=%h", k + 1, green_o, 8'(k - 192));
                end
            end
        end
    endtask

    task automatic test_en_drop(input bit use_rst);
        bit off;
        restart();
        for (int k = 0; k <= 40; k++) begin
            off = (k >= 10 && k < 30);
            step(use_rst & off, use_rst | ~off, 2'd0);
            checks++;
            if (dut_v !== exp_v) begin
                errors++;
                $display("FAIL drop_pix rst=%0b c=%0d got=%h exp=%h", use_rst, k + 1, dut_v, exp_v);
            end
            if (k + 1 >= 11 && k + 1 <= 30) begin
                checks++;
                if (dut_v !== 28'h0) begin
                    errors++;
                    $display("FAIL drop_idle rst=%0b c=%0d got=%h exp=0", use_rst, k + 1, dut_v);
                end
            end
            if (k + 1 == 31) begin
                checks++;
                if (sof_o !== 1'b1 || {red_o, green_o, blue_o} !== 24'hFFFFFF) begin
                    errors++;
                    $display("FAIL restart_px rst=%0b got sof=%b rgb=%h exp 1 ffffff",
                        use_rst, sof_o, {red_o, green_o, blue_o});
                end
            end
        end
    endtask

    task automatic test_scroll();
        logic [7:0] e;
        restart();
        for (int c = 1; c <= 2 * FT + 20; c++) begin
            step(1'b0, 1'b1, 2'd1);
            checks++;
            if (dut_v !== exp_v) begin
                errors++;
                $display("FAIL scroll_pix c=%0d got=%h exp=%h", c, dut_v, exp_v);
            end
            if (c == 1 || c == 193 || c == 208) begin
`ifdef VIDEO_PATTERN_GEN_SCROLL_EN
                e = (c == 193) ? 8'h01 : 8'h00;
`else
                e = (c == 208) ? 8'h0F : 8'h00;
`endif
                checks++;
                if (blue_o !== e) begin
                    errors++;
                    $display("FAIL scroll_fixed c=%0d got=%h exp=%h", c, blue_o, e);
                end
            end
        end
    endtask

    task automatic test_random();
        bit r, e;
        restart();
        for (int k = 0; k < 5000; k++) begin
            r = ($urandom_range(0, 1999) == 0);
            e = ($urandom_range(0, 799) != 0);
            step(r, e, 2'($urandom));
            checks++;
            if (dut_v !== exp_v) begin
                errors++;
                $display("FAIL random_pix k=%0d got=%h exp=%h", k, dut_v, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_checker();
        test_sel_change();
        test_en_drop(1'b0);
        test_en_drop(1'b1);
        test_scroll();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
